// File: rtl/cpu_flags_pkg.sv
// cpu_flags_pkg: shared flag-set type and shadow stack limits
package cpu_flags_pkg;
  localparam int FLAGS_W = 3;
  localparam int MAX_SHADOW_DEPTH = 8;
  typedef struct packed {logic c; logic z; logic i;} flags_t;
endpackage

// File: rtl/flag_shadow_stack.sv
// flag_shadow_stack: DEPTH-entry LIFO of saved {C,Z,I} flag sets
module flag_shadow_stack import cpu_flags_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  flags_t        din,
  output flags_t        top,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          pop_ok,
  output logic          illegal
);
  logic [FLAGS_W-1:0] mem [DEPTH];
  logic push_ok;
  if (DEPTH < 1 || DEPTH > MAX_SHADOW_DEPTH) begin : g_depth_chk
    $error("flag_shadow_stack: DEPTH out of range");
  end
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign illegal = push & pop;
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  // select the entry just below level without a wide array index
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) top = (level == LW'(i + 1)) ? flags_t'(mem[i]) : top;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      level <= push_ok ? level + LW'(1) : pop_ok ? level - LW'(1) : level;
      for (int i = 0; i < DEPTH; i++) if (push_ok && level == LW'(i)) mem[i] <= din;
    end
endmodule

// File: rtl/flag_unit.sv
// flag_unit: live C/Z/I flags with a nestable shadow stack and sticky stack errors
module flag_unit import cpu_flags_pkg::*; #(
  parameter int DEPTH   = 2,
  parameter bit I_RESET = 1'b0,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          C,
  input  logic          C_LD,
  input  logic          C_SET,
  input  logic          C_CLEAR,
  input  logic          Z,
  input  logic          Z_LD,
  input  logic          I_SET,
  input  logic          I_CLR,
  input  logic          FLG_SAVE,
  input  logic          FLG_RESTORE,
  input  logic          ERR_CLR,
  output logic          C_FLAG,
  output logic          Z_FLAG,
  output logic          I_FLAG,
  output logic [LW-1:0] LEVEL,
  output logic          STK_FULL,
  output logic          STK_EMPTY,
  output logic          OVF,
  output logic          UNF
);
  flags_t top;
  logic pop_ok, illegal, ovf_evt, unf_evt, c_nxt, z_nxt, i_nxt;
  flag_shadow_stack #(.DEPTH(DEPTH)) u_stack (
    .clk(clk), .rst_n(rst_n), .push(FLG_SAVE), .pop(FLG_RESTORE),
    .din(flags_t'({C_FLAG, Z_FLAG, I_FLAG})), .top(top), .level(LEVEL),
    .full(STK_FULL), .empty(STK_EMPTY), .pop_ok(pop_ok), .illegal(illegal)
  );
  assign ovf_evt = illegal | (FLG_SAVE & STK_FULL);
  assign unf_evt = illegal | (FLG_RESTORE & STK_EMPTY);
  // interrupt entry clears I even when the push is dropped for overflow
  always_comb begin
    c_nxt = pop_ok ? top.c : C_CLEAR ? 1'b0 : C_SET ? 1'b1 : C_LD ? C : C_FLAG;
    z_nxt = pop_ok ? top.z : Z_LD ? Z : Z_FLAG;
    i_nxt = pop_ok ? top.i : (FLG_SAVE & ~FLG_RESTORE) ? 1'b0 : I_CLR ? 1'b0 : I_SET ? 1'b1 : I_FLAG;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      C_FLAG <= 1'b0;
      Z_FLAG <= 1'b0;
      I_FLAG <= I_RESET;
      OVF    <= 1'b0;
      UNF    <= 1'b0;
    end else begin
      C_FLAG <= c_nxt;
      Z_FLAG <= z_nxt;
      I_FLAG <= i_nxt;
      OVF    <= ovf_evt | (OVF & ~ERR_CLR);
      UNF    <= unf_evt | (UNF & ~ERR_CLR);
    end
endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed plus randomized checks of flag_unit against a queue-based model
module tb_flag_unit;
  localparam int DEPTH = 2;
  localparam int LW = $clog2(DEPTH + 1);
  logic clk = 1'b0, rst_n = 1'b0;
  logic C, C_LD, C_SET, C_CLEAR, Z, Z_LD, I_SET, I_CLR, FLG_SAVE, FLG_RESTORE, ERR_CLR;
  logic C_FLAG, Z_FLAG, I_FLAG, STK_FULL, STK_EMPTY, OVF, UNF;
  logic [LW-1:0] LEVEL;
  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;
  bit mc, mz, mi, movf, munf;
  bit [2:0] mq[$];

  flag_unit #(.DEPTH(DEPTH), .I_RESET(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .C(C), .C_LD(C_LD), .C_SET(C_SET), .C_CLEAR(C_CLEAR),
    .Z(Z), .Z_LD(Z_LD), .I_SET(I_SET), .I_CLR(I_CLR), .FLG_SAVE(FLG_SAVE),
    .FLG_RESTORE(FLG_RESTORE), .ERR_CLR(ERR_CLR), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG),
    .I_FLAG(I_FLAG), .LEVEL(LEVEL), .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY),
    .OVF(OVF), .UNF(UNF)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic clear_in();
    {C, C_LD, C_SET, C_CLEAR, Z, Z_LD, I_SET, I_CLR, FLG_SAVE, FLG_RESTORE, ERR_CLR} = '0;
  endtask

  task automatic reset_model();
    {mc, mz, mi, movf, munf} = '0;
    mq.delete();
  endtask

  // model of one clock edge, written from the flag/stack rules
  task automatic model_edge();
    int n = mq.size();
    bit sv = FLG_SAVE, rs = FLG_RESTORE;
    bit [2:0] t;
    if (rs && !sv && n > 0) begin
      t = mq.pop_back();
      {mc, mz, mi} = t;
    end else begin
      if (sv && !rs && n < DEPTH) mq.push_back({mc, mz, mi});
      if (C_CLEAR) mc = 0; else if (C_SET) mc = 1; else if (C_LD) mc = C;
      if (Z_LD) mz = Z;
      if (sv && !rs) mi = 0; else if (I_CLR) mi = 0; else if (I_SET) mi = 1;
    end
    movf = (sv && (rs || n == DEPTH)) ? 1'b1 : (ERR_CLR ? 1'b0 : movf);
    munf = (rs && (sv || n == 0)) ? 1'b1 : (ERR_CLR ? 1'b0 : munf);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    clear_in();
  endtask

  always @(negedge clk) if (chk_en) begin
    check("m_c", C_FLAG, mc);
    check("m_z", Z_FLAG, mz);
    check("m_i", I_FLAG, mi);
    check("m_level", LEVEL, mq.size());
    check("m_full", STK_FULL, mq.size() == DEPTH);
    check("m_empty", STK_EMPTY, mq.size() == 0);
    check("m_ovf", OVF, movf);
    check("m_unf", UNF, munf);
  end

  task automatic async_reset();
    #2 rst_n = 1'b0;
    reset_model();
    #1;
    check("ar_c", C_FLAG, 0); check("ar_z", Z_FLAG, 0); check("ar_i", I_FLAG, 0);
    check("ar_level", LEVEL, 0); check("ar_ovf", OVF, 0); check("ar_unf", UNF, 0);
    check("ar_empty", STK_EMPTY, 1);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    clear_in();
    reset_model();
    repeat (2) @(negedge clk);
    check("rst_c", C_FLAG, 0); check("rst_z", Z_FLAG, 0); check("rst_i", I_FLAG, 0);
    check("rst_level", LEVEL, 0); check("rst_empty", STK_EMPTY, 1);
    check("rst_ovf", OVF, 0); check("rst_unf", UNF, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    C = 1; C_LD = 1; Z = 1; Z_LD = 1; step();
    check("ld_c", C_FLAG, 1); check("ld_z", Z_FLAG, 1); check("ld_i", I_FLAG, 0);
    C_CLEAR = 1; C_LD = 1; C = 1; step();
    check("clr_prio", C_FLAG, 0);
    C_SET = 1; Z_LD = 1; Z = 0; I_SET = 1; step();
    FLG_SAVE = 1; C_LD = 1; C = 0; step();
    check("sv_level", LEVEL, 1); check("sv_c", C_FLAG, 0); check("sv_i", I_FLAG, 0);
    FLG_RESTORE = 1; step();
    check("rs_c", C_FLAG, 1); check("rs_z", Z_FLAG, 0); check("rs_i", I_FLAG, 1);
    check("rs_level", LEVEL, 0);
    FLG_SAVE = 1; step();
    C_CLEAR = 1; Z_LD = 1; Z = 1; I_SET = 1; step();
    FLG_SAVE = 1; step();
    C_SET = 1; I_SET = 1; step();
    FLG_SAVE = 1; step();
    check("n_level", LEVEL, 2); check("n_full", STK_FULL, 1); check("n_ovf", OVF, 1);
    check("n_i", I_FLAG, 0);
    FLG_RESTORE = 1; step();
    check("pop_b", {C_FLAG, Z_FLAG, I_FLAG}, 3'b011);
    FLG_RESTORE = 1; step();
    check("pop_a", {C_FLAG, Z_FLAG, I_FLAG}, 3'b101); check("pop_empty", STK_EMPTY, 1);
    ERR_CLR = 1; step();
    check("ovf_clr", OVF, 0);
    FLG_RESTORE = 1; Z_LD = 1; Z = 1; step();
    check("unf_z", Z_FLAG, 1); check("unf_set", UNF, 1); check("unf_level", LEVEL, 0);
    ERR_CLR = 1; step();
    check("unf_clr", UNF, 0);
    I_SET = 1; step();
    FLG_SAVE = 1; step();
    C_CLEAR = 1; Z_LD = 1; Z = 0; step();
    FLG_SAVE = 1; FLG_RESTORE = 1; I_SET = 1; step();
    check("ill_level", LEVEL, 1); check("ill_ovf", OVF, 1); check("ill_unf", UNF, 1);
    check("ill_i", I_FLAG, 1);
    FLG_RESTORE = 1; ERR_CLR = 1; step();
    check("ill_top", {C_FLAG, Z_FLAG, I_FLAG}, 3'b111); check("ill_errclr", OVF, 0);
    FLG_SAVE = 1; step();
    FLG_SAVE = 1; step();
    FLG_SAVE = 1; step();
    check("pre_ar_level", LEVEL, 2); check("pre_ar_ovf", OVF, 1);
    async_reset();
    @(negedge clk);
    FLG_RESTORE = 1; step();
    check("post_ar_unf", UNF, 1);
    for (int k = 0; k < 800; k++) begin
      C = 1'($urandom); Z = 1'($urandom);
      C_LD = $urandom_range(0, 2) == 0; C_SET = $urandom_range(0, 4) == 0;
      C_CLEAR = $urandom_range(0, 4) == 0; Z_LD = $urandom_range(0, 2) == 0;
      I_SET = $urandom_range(0, 3) == 0; I_CLR = $urandom_range(0, 3) == 0;
      FLG_SAVE = $urandom_range(0, 2) == 0; FLG_RESTORE = $urandom_range(0, 2) == 0;
      ERR_CLR = $urandom_range(0, 7) == 0;
      if (k == 400) async_reset();
      step();
    end
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
